// File: rtl/spi_byte_master.sv
// Byte-wide SPI master, mode 0, MSB first, with a selectable slow init rate.
// Two-process FSM: registered state plus one combinational next-value block, all gated by ce.
module spi_byte_master #(
    parameter int FAST_DIV = 1,
    parameter int SLOW_DIV = 64,
    parameter int DIVW     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] idata,
    input  logic       wr,
    output logic [7:0] odata,
    output logic       dsr,
    output logic       busy,
    input  logic       slow,
    input  logic       cs,
    output logic       ss_n,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    localparam logic [DIVW-1:0] FAST_D = DIVW'(FAST_DIV);
    localparam logic [DIVW-1:0] SLOW_D = DIVW'(SLOW_DIV);
    localparam logic [DIVW-1:0] ONE_D  = DIVW'(1);

    state_t          r_state, w_state;
    logic            r_sck, w_sck;
    logic            r_mosi, w_mosi;
    logic            r_ss_n;
    logic            r_dsr, w_dsr;
    logic            r_busy, w_busy;
    logic [7:0]      r_odata, w_odata;
    logic [6:0]      r_txsh, w_txsh;
    logic [7:0]      r_rxsh, w_rxsh;
    logic [2:0]      r_bitcnt, w_bitcnt;
    logic [DIVW-1:0] r_div, w_div;
    logic [DIVW-1:0] r_divcnt, w_divcnt;

    // NOTE: every next-value gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state  = r_state;
        w_sck    = r_sck;
        w_mosi   = r_mosi;
        w_dsr    = 1'b0;
        w_busy   = r_busy;
        w_odata  = r_odata;
        w_txsh   = r_txsh;
        w_rxsh   = r_rxsh;
        w_bitcnt = r_bitcnt;
        w_div    = r_div;
        w_divcnt = r_divcnt;

        case (r_state)
            S_IDLE: begin
                w_sck  = 1'b0;
                w_busy = 1'b0;
                if (wr) begin
                    w_txsh   = idata[6:0];
                    w_mosi   = idata[7];
                    w_bitcnt = 3'd0;
                    w_div    = slow ? SLOW_D : FAST_D;
                    w_divcnt = w_div - ONE_D;
                    w_busy   = 1'b1;
                    w_state  = S_LOW;
                end
            end
            S_LOW: begin
                if (r_divcnt != '0) begin
                    w_divcnt = r_divcnt - ONE_D;
                end else begin
                    w_sck    = 1'b1;
                    w_rxsh   = {r_rxsh[6:0], miso};
                    w_divcnt = r_div - ONE_D;
                    w_state  = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_divcnt != '0) begin
                    w_divcnt = r_divcnt - ONE_D;
                end else begin
                    w_sck    = 1'b0;
                    w_divcnt = r_div - ONE_D;
                    if (r_bitcnt != 3'd7) begin
                        // Remaining tx bits shift out of the top of txsh on each falling sck.
                        w_mosi   = r_txsh[6];
                        w_txsh   = {r_txsh[5:0], 1'b0};
                        w_bitcnt = r_bitcnt + 3'd1;
                        w_state  = S_LOW;
                    end else begin
                        w_odata = r_rxsh;
                        w_dsr   = 1'b1;
                        w_busy  = 1'b0;
                        w_mosi  = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b1;
            r_ss_n   <= 1'b1;
            r_dsr    <= 1'b0;
            r_busy   <= 1'b0;
            r_odata  <= 8'hFF;
            r_txsh   <= '0;
            r_rxsh   <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_divcnt <= '0;
        end else if (ce) begin
            r_ss_n   <= ~cs;
            r_state  <= w_state;
            r_sck    <= w_sck;
            r_mosi   <= w_mosi;
            r_dsr    <= w_dsr;
            r_busy   <= w_busy;
            r_odata  <= w_odata;
            r_txsh   <= w_txsh;
            r_rxsh   <= w_rxsh;
            r_bitcnt <= w_bitcnt;
            r_div    <= w_div;
            r_divcnt <= w_divcnt;
        end
    end

    assign odata = r_odata;
    assign dsr   = r_dsr;
    assign busy  = r_busy;
    assign ss_n  = r_ss_n;
    assign sck   = r_sck;
    assign mosi  = r_mosi;

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Byte-wide SPI master (mode 0, MSB first) for the floppy/SD path.
- Sits directly downstream of the block DMA engine. It consumes that engine's byte strobe and transmit data, and returns received data with a one-cycle data-ready pulse.
- Also drives SD chip select and supports a slow init clock rate.
- The engine pumps 512-byte blocks by issuing one wr per byte and waiting for dsr.

Parameters:
FAST_DIV, 1, SCK half-period in ce-cycles in normal mode (>=1)
SLOW_DIV, 64, SCK half-period in ce-cycles when slow=1 (SD init <=400 kHz)
DIVW, 8, width of divider counter

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state advances only when ce=1
idata  in  8  byte to transmit, sampled on accepted wr
wr  in  1  transfer request, level-sampled on ce cycles
odata  out  8  last received byte, valid from dsr onward
dsr  out  1  data-ready pulse, exactly one ce-cycle per completed byte
busy  out  1  1 while a byte is in flight
slow  in  1  selects SLOW_DIV, latched at transfer accept
cs  in  1  chip-select request from host register
ss_n  out  1  SPI slave select, registered ~cs
sck  out  1  SPI clock, idle low
mosi  out  1  SPI data out
miso  in  1  SPI data in

Behaviour:
- Reset (asynchronous, reset_n=0), effective immediately including mid-byte:
  - state=IDLE, sck=0, mosi=1, ss_n=1, dsr=0, busy=0, odata=8'hFF.
  - Shift register and counters cleared.
  - Any byte in progress is aborted with no dsr.
- All registers other than ss_n update only on clk edges with ce=1. ss_n <= ~cs every ce edge, independent of state.
- State machine: IDLE, LOW, HIGH.
- IDLE:
  - sck=0, busy=0.
  - On wr=1:
    - txsh<=idata, mosi<=idata[7], bitcnt<=0
    - div<=slow?SLOW_DIV:FAST_DIV, divcnt<=div-1
    - busy<=1, state<=LOW
  - dsr<=0 on every IDLE edge without completion.
- LOW:
  - If divcnt!=0: divcnt--.
  - Else: sck<=1, rxsh<={rxsh[6:0],miso}, divcnt<=div-1, state<=HIGH.
  - miso is sampled on the same edge that raises sck.
- HIGH:
  - If divcnt!=0: divcnt--.
  - Else: sck<=0, divcnt<=div-1.
    - If bitcnt!=7: mosi<=txsh[6-bitcnt] (next bit), bitcnt++, state<=LOW.
    - If bitcnt==7: odata<=rxsh, dsr<=1, busy<=0, mosi<=1, state<=IDLE.
- Latency:
  - Accept edge is E0. Each half-period is exactly div ce-edges.
  - Byte completes at edge E(16*div). dsr is high from then until E(16*div+1).
- dsr:
  - Never asserted on the accept edge.
  - Cleared on the next ce edge even if a new wr is accepted on that edge (back-to-back allowed).
- wr while busy=1: ignored, with no queueing. The upstream engine must not re-assert wr until it has seen dsr.
- Changing slow or cs mid-byte: does not affect the current byte's rate. ss_n follows cs anyway; protocol correctness is the host's responsibility.
- ce=0: all outputs hold, including dsr. dsr pulse width is counted in ce-cycles, not clk cycles.
- Divider: divcnt is DIVW bits. A div value of 0 is illegal; parameters must be >=1.
- Upstream convention: when reading, the engine sends 8'hFF; this block treats it as ordinary data.

Test Plan:
- FAST_DIV=1, slow=0, wr with idata=8'hA5, miso model returns 8'h3C:
  - mosi bits at sck rising edges = 1,0,1,0,0,1,0,1.
  - odata=8'h3C; dsr high only after E16 for one ce-cycle; busy high E0..E16.
- slow=1, SLOW_DIV=4, byte 8'hFF:
  - sck period = 8 ce-cycles; dsr after E64; odata=8'hFF with miso tied high.
- Back-to-back: wr held high through dsr with idata 8'h01 then 8'h80:
  - second byte accepted on the edge clearing dsr; exactly two dsr pulses.
- ce gating: ce toggling 1-0-1-0 during an FAST_DIV=1 byte:
  - dsr after 16 ce-enabled edges (32 clk); dsr high for 2 clk (one ce-cycle).
- Reset mid-byte: reset_n=0 after 5 bits:
  - immediately sck=0, ss_n=1, mosi=1, busy=0, odata=8'hFF; no dsr.
  - Next wr completes a full byte normally.
- wr pulsed while busy:
  - ignored; only one byte is transferred; cs=1 gives ss_n=0 one ce-edge later.
